// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 key search controller.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_CORE,
    RD_LEN,
    CHECK,
    NEXT,
    DONE
  } state_t;

  localparam logic [7:0] PT_MIN = 8'h20;
  localparam logic [7:0] PT_MAX = 8'h7E;

endpackage

// File: rtl/pt_check.sv
// Printable-byte test with a sticky per-key failure flag.
module pt_check
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       chk,
  input  logic [7:0] data,
  output logic       failed
);

  logic in_range;
  logic fail_q;

  assign in_range = (data >= PT_MIN) && (data <= PT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                fail_q <= 1'b0;
    else if (clr)              fail_q <= 1'b0;
    else if (chk && !in_range) fail_q <= 1'b1;
  end

  // Reported in the same cycle the bad byte is tested.
  assign failed = fail_q | (chk & ~in_range);

endmodule

// File: rtl/arc4_keysearch.sv
// Drives an external ARC4 core over one key or a key range and accepts
// the first key whose decrypted plaintext is entirely printable.
//
// state     | meaning
// IDLE      | ready, waiting for en
// LAUNCH    | wait for core ready, then one-cycle a4_en pulse
// WAIT_CORE | core busy; first cycle ignores a4_rdy
// RD_LEN    | read plaintext length at address 0
// CHECK     | pipelined printable test of bytes 1..len
// NEXT      | advance key or finish with no match
// DONE      | ready, results held
module arc4_keysearch
  import arc4_pkg::*;
#(
  parameter int KEY_W     = 24,
  parameter int KEY_START = 0,
  parameter int KEY_STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             rdy,
  input  logic             mode,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_valid,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W:0]   keys_tried,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [23:0]      a4_key,
  output logic [7:0]       pt_addr,
  input  logic [7:0]       pt_rddata
);

  state_t           state, state_n;
  logic [KEY_W-1:0] cur_key, cur_key_n;
  logic             mode_q, mode_n;
  logic [KEY_W:0]   keys_tried_n;
  logic             key_valid_n;
  logic [KEY_W-1:0] key_out_n;
  logic             a4_en_n;
  logic [7:0]       pt_addr_n;
  logic [7:0]       len, len_n;
  logic [7:0]       data_idx;
  logic             first, first_n;
  logic             pt_fail;
  logic [31:0]      key_sum;
  logic             exhausted;

  // Wide sum so any step size reports a carry out of the key space.
  assign key_sum   = 32'(cur_key) + 32'(KEY_STEP);
  assign exhausted = key_sum >= (32'd1 << KEY_W);

  assign rdy    = (state == IDLE) || (state == DONE);
  assign a4_key = 24'(cur_key);

  pt_check u_pt_check (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == LAUNCH),
    .chk   ((state == CHECK) && !first),
    .data  (pt_rddata),
    .failed(pt_fail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_key    <= '0;
      mode_q     <= 1'b0;
      keys_tried <= '0;
      key_valid  <= 1'b0;
      key_out    <= '0;
      a4_en      <= 1'b0;
      pt_addr    <= '0;
      len        <= '0;
      data_idx   <= '0;
      first      <= 1'b0;
    end else begin
      state      <= state_n;
      cur_key    <= cur_key_n;
      mode_q     <= mode_n;
      keys_tried <= keys_tried_n;
      key_valid  <= key_valid_n;
      key_out    <= key_out_n;
      a4_en      <= a4_en_n;
      pt_addr    <= pt_addr_n;
      len        <= len_n;
      data_idx   <= pt_addr;
      first      <= first_n;
    end
  end

  always_comb begin
    state_n      = state;
    cur_key_n    = cur_key;
    mode_n       = mode_q;
    keys_tried_n = keys_tried;
    key_valid_n  = key_valid;
    key_out_n    = key_out;
    a4_en_n      = 1'b0;
    pt_addr_n    = pt_addr;
    len_n        = len;

    case (state)
      IDLE, DONE: begin
        if (en) begin
          cur_key_n    = mode ? KEY_W'(KEY_START) : key_in;
          mode_n       = mode;
          keys_tried_n = '0;
          key_valid_n  = 1'b0;
          key_out_n    = '0;
          state_n      = LAUNCH;
        end
      end
      LAUNCH: begin
        if (a4_en)       state_n = WAIT_CORE;
        else if (a4_rdy) a4_en_n = 1'b1;
      end
      WAIT_CORE: begin
        if (!first && a4_rdy) begin
          keys_tried_n = keys_tried + (KEY_W+1)'(1);
          pt_addr_n    = '0;
          state_n      = RD_LEN;
        end
      end
      RD_LEN: begin
        if (!first) begin
          len_n = pt_rddata;
          if (pt_rddata == 8'd0) begin
            state_n = NEXT;
          end else begin
            pt_addr_n = 8'd1;
            state_n   = CHECK;
          end
        end
      end
      CHECK: begin
        if (pt_fail) begin
          state_n = NEXT;
        end else begin
          if (!first && (data_idx == len)) begin
            key_out_n   = cur_key;
            key_valid_n = 1'b1;
            state_n     = DONE;
          end
          if (pt_addr != len) pt_addr_n = pt_addr + 8'd1;
        end
      end
      NEXT: begin
        if (!mode_q || exhausted) begin
          state_n = DONE;
        end else begin
          cur_key_n = key_sum[KEY_W-1:0];
          state_n   = LAUNCH;
        end
      end
      default: state_n = IDLE;
    endcase

    first_n = (state_n != state);
  end

endmodule
